// File: rtl/dmem_lsu_pkg.sv
// Shared types and defaults for the dmem_lsu load/store initiator.
// Optional statistics counters are enabled with the DMEM_LSU_STATS_EN macro.
package dmem_lsu_pkg;

    localparam int LSU_DATA_W    = 16;
    localparam int LSU_ADDR_W    = 16;
    localparam int LSU_MEM_DEPTH = 16;
    localparam int LSU_STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic                  we;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
    } lsu_req_t;

    // Unsigned full-width range check; no wrap of large addresses.
    function automatic logic addr_in_range(input logic [LSU_ADDR_W-1:0] addr,
                                           input int unsigned           depth);
        return ({{(32-LSU_ADDR_W){1'b0}}, addr} < depth);
    endfunction

endpackage

// File: rtl/dmem_lsu_stat_ctr.sv
// Saturating event counter with synchronous clear, used for LSU statistics
// (only instantiated when DMEM_LSU_STATS_EN is defined).
module dmem_lsu_stat_ctr
    import dmem_lsu_pkg::*;
#(
    parameter int W = LSU_STAT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the 16-bit MIPS data memory.
// Accepts one request at a time, issues a single-cycle memory strobe, and
// returns a registered response. Out-of-range addresses skip memory entirely.
// Define DMEM_LSU_STATS_EN to add load/store/error statistic outputs.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_W    = LSU_DATA_W,
    parameter int ADDR_W    = LSU_ADDR_W,
    parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_LSU_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    lsu_state_t state, state_nxt;
    lsu_req_t   req_q;
    logic       accept;
    logic       in_range;

    assign accept   = (state == IDLE) && req_valid;
    assign in_range = addr_in_range(req_addr, MEM_DEPTH);

    // Memory port is driven straight from the captured request, so it holds
    // its last value in every state except while a new request is issued.
    assign mem_access_addr = req_q.addr;
    assign mem_write_data  = req_q.wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        mem_write_en = 1'b0;
        mem_read     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = in_range ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                mem_write_en = req_q.we;
                mem_read     = !req_q.we;
                state_nxt    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and response data. Error responses are built at
    // acceptance; the request register is left untouched so memory never
    // sees an out-of-range address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                if (in_range) begin
                    req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
                end else begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            if (state == ISSUE) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= req_q.we ? '0 : mem_read_data;
            end
        end
    end

`ifdef DMEM_LSU_STATS_EN
    logic inc_load, inc_store, inc_err;

    assign inc_load  = (state == ISSUE) && !req_q.we;
    assign inc_store = (state == ISSUE) &&  req_q.we;
    assign inc_err   = accept && !in_range;

    dmem_lsu_stat_ctr #(.W(16)) u_ctr_loads (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (inc_load),
        .count (stat_loads)
    );

    dmem_lsu_stat_ctr #(.W(16)) u_ctr_stores (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (inc_store),
        .count (stat_stores)
    );

    dmem_lsu_stat_ctr #(.W(16)) u_ctr_errs (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (inc_err),
        .count (stat_errs)
    );
`endif

endmodule
